// File: rtl/pwm_wave_gen.sv
// PWM waveform generator: a free-running PWM counter whose duty steps through a
// square, sawtooth, triangle or manual-level profile with prescaler and phase offset.
module pwm_wave_gen #(
    parameter int CNT_W   = 6,
    parameter int IDX_W   = 6,
    parameter int PRESC_W = 8
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic [IDX_W-1:0]   phase,
    input  logic [CNT_W:0]     level,
    output logic               pulse,
    output logic [CNT_W:0]     duty,
    output logic               period_start,
    output logic               wave_start
);

    localparam int N = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [IDX_W-1:0] IDX_MAX   = '1;
    localparam logic [IDX_W-1:0] SQ_LO     = IDX_W'(N / 4);
    localparam logic [IDX_W-1:0] SQ_HI     = IDX_W'((3 * N) / 4);
    localparam logic [CNT_W:0]   DUTY_FULL = {1'b1, {CNT_W{1'b0}}};

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W:0]     duty_q, duty_d;
    logic [1:0]         mode_l_q, mode_l_d;
    logic [IDX_W-1:0]   phase_l_q, phase_l_d;
    logic [PRESC_W-1:0] presc_l_q, presc_l_d;
    logic               running_q, running_d;
    logic               pulse_q, pulse_d;
    logic               period_start_q, period_start_d;
    logic               wave_start_q, wave_start_d;

    logic               wrap, psc_term, idx_step, wave_wrap, load, upd;
    logic [1:0]         mode_use;
    logic [IDX_W-1:0]   phase_use, idx_new, e, tri_in, sc_in;
    logic [CNT_W-1:0]   sc_out;
    logic [CNT_W:0]     duty_new;

    // MSB-first alignment of the waveform index onto the counter width.
    if (IDX_W >= CNT_W) begin : g_trunc
        assign sc_out = sc_in[IDX_W-1 -: CNT_W];
    end else begin : g_pad
        assign sc_out = {sc_in, {(CNT_W - IDX_W){1'b0}}};
    end

    always_comb begin
        wrap      = (cnt_q == CNT_MAX);
        psc_term  = (psc_cnt_q == presc_l_q);
        idx_step  = wrap & psc_term;
        wave_wrap = idx_step & (idx_q == IDX_MAX);
        // Controls are taken fresh at run start and at every waveform boundary,
        // and the duty computed at that edge already uses the fresh values.
        load      = ~running_q | wave_wrap;
        upd       = ~running_q | wrap;
        mode_use  = load ? mode  : mode_l_q;
        phase_use = load ? phase : phase_l_q;
        idx_new   = idx_step ? idx_q + 1'b1 : idx_q;
        e         = idx_new + phase_use;
        tri_in    = e[IDX_W-1] ? ((~e) << 1) : (e << 1);
        sc_in     = (mode_use == 2'b10) ? tri_in : e;

        case (mode_use)
            2'b00:   duty_new = ((e >= SQ_LO) && (e < SQ_HI)) ? DUTY_FULL : '0;
            2'b01,
            2'b10:   duty_new = {1'b0, sc_out};
            default: duty_new = (level > DUTY_FULL) ? DUTY_FULL : level;
        endcase

        cnt_d          = cnt_q + 1'b1;
        psc_cnt_d      = psc_cnt_q;
        if (wrap) begin
            psc_cnt_d = psc_term ? '0 : psc_cnt_q + 1'b1;
        end
        idx_d          = idx_new;
        duty_d         = upd ? duty_new : duty_q;
        mode_l_d       = mode_use;
        phase_l_d      = phase_use;
        presc_l_d      = load ? presc : presc_l_q;
        running_d      = 1'b1;
        pulse_d        = ({1'b0, cnt_q} < duty_q);
        period_start_d = (cnt_q == '0);
        wave_start_d   = (cnt_q == '0) && (idx_q == '0) && (psc_cnt_q == '0);

        if (!enable) begin
            cnt_d          = '0;
            psc_cnt_d      = '0;
            idx_d          = '0;
            duty_d         = '0;
            mode_l_d       = mode_l_q;
            phase_l_d      = phase_l_q;
            presc_l_d      = presc_l_q;
            running_d      = 1'b0;
            pulse_d        = 1'b0;
            period_start_d = 1'b0;
            wave_start_d   = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_q          <= '0;
            psc_cnt_q      <= '0;
            idx_q          <= '0;
            duty_q         <= '0;
            mode_l_q       <= '0;
            phase_l_q      <= '0;
            presc_l_q      <= '0;
            running_q      <= 1'b0;
            pulse_q        <= 1'b0;
            period_start_q <= 1'b0;
            wave_start_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            psc_cnt_q      <= psc_cnt_d;
            idx_q          <= idx_d;
            duty_q         <= duty_d;
            mode_l_q       <= mode_l_d;
            phase_l_q      <= phase_l_d;
            presc_l_q      <= presc_l_d;
            running_q      <= running_d;
            pulse_q        <= pulse_d;
            period_start_q <= period_start_d;
            wave_start_q   <= wave_start_d;
        end
    end

    assign pulse        = pulse_q;
    assign duty         = duty_q;
    assign period_start = period_start_q;
    assign wave_start   = wave_start_q;

endmodule

// File: tb/tb_pwm_wave_gen.sv
// Directed bench for pwm_wave_gen: records outputs per cycle after each enabled
// edge (index k = k-th enabled edge) and compares against hand-computed values.
module tb_pwm_wave_gen;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] presc;
    logic [5:0] phase;
    logic [6:0] level;
    logic       pulse;
    logic [6:0] duty;
    logic       period_start;
    logic       wave_start;

    int checks = 0;
    int fails  = 0;

    bit         p_h  [0:16383];
    bit         ws_h [0:16383];
    bit         ps_h [0:16383];
    logic [6:0] d_h  [0:16383];

    pwm_wave_gen #(.CNT_W(6), .IDX_W(6), .PRESC_W(8)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .presc       (presc),
        .phase       (phase),
        .level       (level),
        .pulse       (pulse),
        .duty        (duty),
        .period_start(period_start),
        .wave_start  (wave_start)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic record(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            tick();
            p_h[k]  = pulse;
            ws_h[k] = wave_start;
            ps_h[k] = period_start;
            d_h[k]  = duty;
        end
    endtask

    // One idle cycle, then apply controls with enable high; next edge is k=0.
    task automatic start_run(input logic [1:0] m, input logic [7:0] ps,
                             input logic [5:0] ph, input logic [6:0] lv);
        rst = 1'b0; enable = 1'b0;
        tick();
        mode = m; presc = ps; phase = ph; level = lv; enable = 1'b1;
    endtask

    function automatic int sum_p(input int lo, input int hi);
        int s;
        s = 0;
        for (int k = lo; k <= hi; k++) s += int'(p_h[k]);
        return s;
    endfunction

    function automatic int sum_ws(input int lo, input int hi);
        int s;
        s = 0;
        for (int k = lo; k <= hi; k++) s += int'(ws_h[k]);
        return s;
    endfunction

    function automatic int sum_ps(input int lo, input int hi);
        int s;
        s = 0;
        for (int k = lo; k <= hi; k++) s += int'(ps_h[k]);
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; mode = 2'b11; level = 7'd64; presc = 8'd0; phase = 6'd0;
        repeat (3) tick();
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %0b want 0", pulse); end
        checks++; if (duty !== 7'd0) begin fails++; $display("FAIL reset_duty: got %0d want 0", duty); end
        checks++; if (period_start !== 1'b0) begin fails++; $display("FAIL reset_ps: got %0b want 0", period_start); end
        checks++; if (wave_start !== 1'b0) begin fails++; $display("FAIL reset_ws: got %0b want 0", wave_start); end
        $display("reset: pulse=%0b duty=%0d ps=%0b ws=%0b", pulse, duty, period_start, wave_start);
    endtask

    task automatic test_square();
        start_run(2'b00, 8'd0, 6'd0, 7'd0);
        record(0, 4096);
        checks++; if (ws_h[0] !== 1'b1) begin fails++; $display("FAIL sq_ws0: got %0b want 1", ws_h[0]); end
        checks++; if (ps_h[0] !== 1'b1) begin fails++; $display("FAIL sq_ps0: got %0b want 1", ps_h[0]); end
        checks++; if (sum_p(0, 1023) !== 0) begin fails++; $display("FAIL sq_low1: got %0d want 0", sum_p(0, 1023)); end
        checks++; if (sum_p(1024, 3071) !== 2048) begin fails++; $display("FAIL sq_high: got %0d want 2048", sum_p(1024, 3071)); end
        checks++; if (sum_p(3072, 4095) !== 0) begin fails++; $display("FAIL sq_low2: got %0d want 0", sum_p(3072, 4095)); end
        checks++; if (sum_ws(1, 4095) !== 0) begin fails++; $display("FAIL sq_ws_mid: got %0d want 0", sum_ws(1, 4095)); end
        checks++; if (ws_h[4096] !== 1'b1) begin fails++; $display("FAIL sq_ws4096: got %0b want 1", ws_h[4096]); end
        checks++; if (sum_ps(0, 4095) !== 64) begin fails++; $display("FAIL sq_ps_count: got %0d want 64", sum_ps(0, 4095)); end
        checks++; if (d_h[1022] !== 7'd0) begin fails++; $display("FAIL sq_duty1022: got %0d want 0", d_h[1022]); end
        checks++; if (d_h[1023] !== 7'd64) begin fails++; $display("FAIL sq_duty1023: got %0d want 64", d_h[1023]); end
        $display("square: high=%0d wave_starts=%0d period_starts=%0d", sum_p(0, 4095), sum_ws(0, 4096), sum_ps(0, 4095));
    endtask

    task automatic test_sawtooth();
        start_run(2'b01, 8'd0, 6'd0, 7'd0);
        record(0, 4095);
        checks++; if (sum_p(0, 63) !== 0) begin fails++; $display("FAIL saw_idx0: got %0d want 0", sum_p(0, 63)); end
        checks++; if (sum_p(640, 703) !== 10) begin fails++; $display("FAIL saw_idx10: got %0d want 10", sum_p(640, 703)); end
        checks++; if (sum_p(4032, 4095) !== 63) begin fails++; $display("FAIL saw_idx63: got %0d want 63", sum_p(4032, 4095)); end
        checks++; if (d_h[640] !== 7'd10) begin fails++; $display("FAIL saw_duty10: got %0d want 10", d_h[640]); end
        $display("sawtooth: idx10=%0d idx63=%0d", sum_p(640, 703), sum_p(4032, 4095));
    endtask

    task automatic test_triangle();
        start_run(2'b10, 8'd0, 6'd0, 7'd0);
        record(0, 4095);
        checks++; if (sum_p(1984, 2047) !== 62) begin fails++; $display("FAIL tri_idx31: got %0d want 62", sum_p(1984, 2047)); end
        checks++; if (sum_p(2048, 2111) !== 62) begin fails++; $display("FAIL tri_idx32: got %0d want 62", sum_p(2048, 2111)); end
        checks++; if (sum_p(64, 127) !== 2) begin fails++; $display("FAIL tri_idx1: got %0d want 2", sum_p(64, 127)); end
        checks++; if (sum_p(4032, 4095) !== 0) begin fails++; $display("FAIL tri_idx63: got %0d want 0", sum_p(4032, 4095)); end
        $display("triangle: idx1=%0d idx31=%0d idx32=%0d idx63=%0d", sum_p(64, 127), sum_p(1984, 2047), sum_p(2048, 2111), sum_p(4032, 4095));
    endtask

    task automatic test_phase();
        start_run(2'b00, 8'd0, 6'd16, 7'd0);
        record(0, 4095);
        checks++; if (sum_p(64, 2047) !== 1984) begin fails++; $display("FAIL ph_high: got %0d want 1984", sum_p(64, 2047)); end
        checks++; if (sum_p(2048, 4095) !== 0) begin fails++; $display("FAIL ph_low: got %0d want 0", sum_p(2048, 4095)); end
        checks++; if (d_h[2046] !== 7'd64) begin fails++; $display("FAIL ph_duty2046: got %0d want 64", d_h[2046]); end
        checks++; if (d_h[2047] !== 7'd0) begin fails++; $display("FAIL ph_duty2047: got %0d want 0", d_h[2047]); end
        $display("phase16: high_first_half=%0d high_second_half=%0d", sum_p(64, 2047), sum_p(2048, 4095));
    endtask

    task automatic test_presc();
        start_run(2'b01, 8'd2, 6'd0, 7'd0);
        record(0, 12288);
        checks++; if (ws_h[0] !== 1'b1) begin fails++; $display("FAIL psc_ws0: got %0b want 1", ws_h[0]); end
        checks++; if (ws_h[12288] !== 1'b1) begin fails++; $display("FAIL psc_ws12288: got %0b want 1", ws_h[12288]); end
        checks++; if (sum_ws(1, 12287) !== 0) begin fails++; $display("FAIL psc_ws_mid: got %0d want 0", sum_ws(1, 12287)); end
        checks++; if (d_h[190] !== 7'd0) begin fails++; $display("FAIL psc_duty190: got %0d want 0", d_h[190]); end
        checks++; if (d_h[191] !== 7'd1) begin fails++; $display("FAIL psc_duty191: got %0d want 1", d_h[191]); end
        checks++; if (d_h[383] !== 7'd2) begin fails++; $display("FAIL psc_duty383: got %0d want 2", d_h[383]); end
        checks++; if (sum_p(192, 383) !== 3) begin fails++; $display("FAIL psc_idx1: got %0d want 3", sum_p(192, 383)); end
        $display("presc2: wave_starts=%0d idx1_high=%0d", sum_ws(0, 12288), sum_p(192, 383));
    endtask

    task automatic test_mode_switch();
        start_run(2'b00, 8'd0, 6'd0, 7'd0);
        record(0, 2000);
        mode = 2'b01;
        record(2001, 4800);
        checks++; if (sum_p(2560, 2623) !== 64) begin fails++; $display("FAIL sw_sq40: got %0d want 64", sum_p(2560, 2623)); end
        checks++; if (sum_p(3072, 3135) !== 0) begin fails++; $display("FAIL sw_sq48: got %0d want 0", sum_p(3072, 3135)); end
        checks++; if (ws_h[4096] !== 1'b1) begin fails++; $display("FAIL sw_ws: got %0b want 1", ws_h[4096]); end
        checks++; if (sum_p(4096, 4159) !== 0) begin fails++; $display("FAIL sw_saw0: got %0d want 0", sum_p(4096, 4159)); end
        checks++; if (sum_p(4736, 4799) !== 10) begin fails++; $display("FAIL sw_saw10: got %0d want 10", sum_p(4736, 4799)); end
        $display("mode_switch: sq40=%0d saw10=%0d", sum_p(2560, 2623), sum_p(4736, 4799));
    endtask

    task automatic test_manual();
        start_run(2'b11, 8'd0, 6'd0, 7'd100);
        record(0, 300);
        level = 7'd20;
        record(301, 400);
        checks++; if (d_h[0] !== 7'd64) begin fails++; $display("FAIL man_clip: got %0d want 64", d_h[0]); end
        checks++; if (sum_p(1, 255) !== 255) begin fails++; $display("FAIL man_full: got %0d want 255", sum_p(1, 255)); end
        checks++; if (sum_p(256, 319) !== 64) begin fails++; $display("FAIL man_old_period: got %0d want 64", sum_p(256, 319)); end
        checks++; if (d_h[318] !== 7'd64) begin fails++; $display("FAIL man_duty318: got %0d want 64", d_h[318]); end
        checks++; if (d_h[319] !== 7'd20) begin fails++; $display("FAIL man_duty319: got %0d want 20", d_h[319]); end
        checks++; if (sum_p(320, 383) !== 20) begin fails++; $display("FAIL man_lvl20: got %0d want 20", sum_p(320, 383)); end
        checks++; if (ps_h[320] !== 1'b1) begin fails++; $display("FAIL man_ps320: got %0b want 1", ps_h[320]); end
        $display("manual: full=%0d lvl20=%0d", sum_p(1, 255), sum_p(320, 383));
    endtask

    task automatic test_enable_drop();
        start_run(2'b01, 8'd0, 6'd0, 7'd0);
        record(0, 643);
        checks++; if (p_h[643] !== 1'b1) begin fails++; $display("FAIL en_pre: got %0b want 1", p_h[643]); end
        enable = 1'b0;
        tick();
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL en_off_pulse: got %0b want 0", pulse); end
        checks++; if (duty !== 7'd0) begin fails++; $display("FAIL en_off_duty: got %0d want 0", duty); end
        checks++; if (period_start !== 1'b0) begin fails++; $display("FAIL en_off_ps: got %0b want 0", period_start); end
        enable = 1'b1;
        record(0, 127);
        checks++; if (ws_h[0] !== 1'b1) begin fails++; $display("FAIL en_re_ws: got %0b want 1", ws_h[0]); end
        checks++; if (d_h[62] !== 7'd0) begin fails++; $display("FAIL en_re_duty62: got %0d want 0", d_h[62]); end
        checks++; if (d_h[63] !== 7'd1) begin fails++; $display("FAIL en_re_duty63: got %0d want 1", d_h[63]); end
        checks++; if (sum_p(64, 127) !== 1) begin fails++; $display("FAIL en_re_idx1: got %0d want 1", sum_p(64, 127)); end
        $display("enable_drop: restart ws=%0b idx1_high=%0d", ws_h[0], sum_p(64, 127));
    endtask

    task automatic test_rst_running();
        start_run(2'b11, 8'd0, 6'd0, 7'd64);
        record(0, 127);
        checks++; if (p_h[127] !== 1'b1) begin fails++; $display("FAIL rr_pre: got %0b want 1", p_h[127]); end
        rst = 1'b1;
        tick();
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL rr_pulse: got %0b want 0", pulse); end
        checks++; if (duty !== 7'd0) begin fails++; $display("FAIL rr_duty: got %0d want 0", duty); end
        checks++; if (period_start !== 1'b0) begin fails++; $display("FAIL rr_ps: got %0b want 0", period_start); end
        checks++; if (wave_start !== 1'b0) begin fails++; $display("FAIL rr_ws: got %0b want 0", wave_start); end
        rst = 1'b0;
        $display("rst_running: pulse=%0b duty=%0d", pulse, duty);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'b00; presc = 8'd0; phase = 6'd0; level = 7'd0;
        test_reset();
        test_square();
        test_sawtooth();
        test_triangle();
        test_phase();
        test_presc();
        test_mode_switch();
        test_manual();
        test_enable_drop();
        test_rst_running();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/pwm_wave_gen.md
Name: pwm_wave_gen

Overview:
Parametrised PWM waveform generator. It is the successor to the fixed single-profile square-duty PWM block. A free-running PWM counter produces one output pulse per PWM period. The duty is stepped through a selectable waveform profile (square, sawtooth, triangle or manual level), with a programmable prescaler and phase offset. It drives LED/actuator pulse outputs from switch-controlled top levels.

Parameters:
CNT_W, 6, PWM counter width; PWM period M = 2^CNT_W sysclk cycles
IDX_W, 6, waveform index width; N = 2^IDX_W steps per waveform period
PRESC_W, 8, prescaler width

Ports:
sysclk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  run/gate; low holds the block idle
mode  in  2  00 square, 01 sawtooth, 10 triangle, 11 manual level
presc  in  PRESC_W  PWM periods per index step, minus 1
phase  in  IDX_W  index offset added to the waveform index
level  in  CNT_W+1  manual duty for mode 11
pulse  out  1  PWM output (registered)
duty  out  CNT_W+1  duty value currently applied
period_start  out  1  one-cycle strobe, first cycle of each PWM period
wave_start  out  1  one-cycle strobe, first cycle of each waveform period

Behaviour:
- Reset, and any cycle with enable=0 (sampled at the clock edge):
  - cnt, psc_cnt, idx, duty_reg cleared to 0.
  - pulse, period_start, wave_start are 0 after that edge.
  - rst has priority over enable.
- Run (enable=1):
  - cnt increments every cycle and wraps M-1 -> 0.
  - Wrap event = cycle with cnt==M-1.
  - On a wrap event: if psc_cnt==presc, psc_cnt <= 0 and idx <= idx+1 (mod N); otherwise psc_cnt <= psc_cnt+1.
- Latching of controls:
  - mode_l, phase_l and presc_l are loaded on the first enabled cycle after idle/reset, and on every wrap event where idx wraps N-1 -> 0 with the prescaler terminal.
  - Changing these inputs mid-waveform has no effect until the next waveform start.
  - level is sampled at every wrap event (live in mode 11).
- Duty update:
  - duty_reg changes only on the wrap event (and the first enabled cycle), so there are no glitches inside a PWM period.
  - The new value is f(mode_l, e), with e = (idx_after_update + phase_l) mod N.
  - The PWM period starting at cnt=0 therefore uses the index it runs under.
- scale(x): aligns x MSB-first to CNT_W bits. Zero-pad the LSBs if IDX_W<CNT_W; truncate the LSBs if IDX_W>CNT_W.
- Profiles (width CNT_W+1, value M = 100%):
  - 00 square: M if N/4 <= e < 3N/4, else 0.
  - 01 sawtooth: scale(e).
  - 10 triangle: scale(2e mod N) for e < N/2, else scale(2(N-1-e) mod N). Peak is M-2 at N=M=64.
  - 11 manual: min(level, M).
- pulse:
  - pulse <= enable & (cnt < duty_reg). This is one cycle latency from cnt.
  - duty=0 gives constant low; duty=M gives constant high across period boundaries with no gap.
- Strobes:
  - period_start <= run & cnt==0.
  - wave_start <= run & cnt==0 & idx==0 & psc_cnt==0.
  - Both are registered in the same stage as pulse, so they are aligned with it.
- duty output = duty_reg.
- Full waveform period = M*N*(presc_l+1) cycles.
- presc=0 means the index steps every PWM period.
- Widths: arithmetic on e is mod N; no overflow on level clip.

Test Plan:
- rst=1 for 3 cycles, then enable=1, mode=00, presc=0, phase=0 (defaults) -> pulse low for cycles 1..1024 after enable, high continuously for 2048 cycles, then low to 4096. wave_start fires every 4096 cycles.
- mode=01 -> the PWM period with idx=10 has pulse high exactly 10 cycles; idx=63 has 63 cycles; idx=0 has none.
- mode=10 -> idx=31 and idx=32 both high 62 cycles; idx=1 high 2 cycles; idx=63 high 0 cycles.
- mode=00, phase=16 -> pulse high for idx 0..31 (cycles 1..2048), low for idx 32..63.
- presc=2 -> each idx held for 3 PWM periods (192 cycles); wave_start spacing 12288 cycles.
- mode switched 00 -> 01 mid-waveform -> square continues until the next wave_start, then sawtooth.
- mode=11, level=100 -> duty=64, pulse constantly high.
- level=20 -> 20 high per period; a level change takes effect at the next period_start.
- enable dropped mid-period -> pulse 0 next cycle; on re-enable the profile restarts at idx 0 with wave_start asserted.
- rst asserted with enable=1 -> all outputs 0 next cycle.
